stack_ctrl: RTL and testbench

Stack-pointer controller for the CPU data stack. It owns the depth counter and sequences all accesses to the 2-read/1-write `stack` RAM, which it instantiates internally. It executes the stack opcodes issued by the decode stage and presents top-of-stack (TOS) and next-of-stack (NOS) to the ALU. It guards against overflow and underflow.

---
 rtl/stack_ctrl_pkg.sv | 27 ++
 rtl/stack_ctrl_stack.sv | 39 +++
 rtl/stack_ctrl.sv | 179 +++++++++++++++++
 tb/tb_stack_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// stack_ctrl_pkg
// Shared CPU definitions for the data-stack path: the stack opcode encoding
// used by both the decode stage and stack_ctrl, the controller FSM states and
// the data word width.
// -----------------------------------------------------------------------------
package stack_ctrl_pkg;

  localparam int unsigned DATA_W = 16;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_PUSH  = 3'd1,
    OP_POP   = 3'd2,
    OP_BINOP = 3'd3,
    OP_DUP   = 3'd4,
    OP_SWAP  = 3'd5,
    OP_OVER  = 3'd6
  } stack_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWAP2 = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

endpackage

// File: rtl/stack_ctrl_stack.sv
// -----------------------------------------------------------------------------
// stack
// 2-read/1-write word RAM backing the CPU data stack.
// Ports:
//   clk            clock for the synchronous write port
//   we/waddr/wdata single write port, written on the rising edge
//   raddr_a/rdata_a  asynchronous read port A (used for TOS)
//   raddr_b/rdata_b  asynchronous read port B (used for NOS)
// -----------------------------------------------------------------------------
module stack
  import stack_ctrl_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int SIZE  = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [WIDTH-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [WIDTH-1:0]  raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [WIDTH-1:0]  raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem [SIZE];

  // NOTE: the array has no reset; clearing it would turn the RAM into a
  // wall of flops and the stack never reads a slot it has not written.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/stack_ctrl.sv
// -----------------------------------------------------------------------------
// stack_ctrl
// Stack-pointer controller for the CPU data stack. Owns the depth counter,
// sequences the internal 2R/1W stack RAM, presents TOS/NOS to the ALU and
// (optionally) guards against overflow/underflow.
// Build option: define STACK_GUARD_EN to enable error detection, the ERROR
// state and the sticky error flags; otherwise every op executes and depth wraps.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   op_valid/op_ready  opcode handshake; op is a stack_op_t
//   din                push value (PUSH) or ALU result (BINOP)
//   tos, nos           words at sp-1 and sp-2 (combinational)
//   depth, empty, full number of valid words and its limits
//   err_overflow, err_underflow  sticky error flags
//   err_clr            clears the flags and leaves ERROR
// -----------------------------------------------------------------------------
module stack_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int SIZE  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  stack_op_t         op,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] tos,
  output logic [DATA_W-1:0] nos,
  output logic [WIDTH:0]    depth,
  output logic              empty,
  output logic              full,
  output logic              err_overflow,
  output logic              err_underflow,
  input  logic              err_clr
);

  state_t            state_q, state_d;
  logic [WIDTH:0]    depth_q, depth_d;
  logic [DATA_W-1:0] swap_tmp;
  logic [WIDTH-1:0]  sp, sp_m1, sp_m2;
  logic              accept, bad_ov, bad_un;
  logic              we;
  logic [WIDTH-1:0]  waddr;
  logic [DATA_W-1:0] wdata;

  assign sp       = depth_q[WIDTH-1:0];
  assign sp_m1    = sp - WIDTH'(1);
  assign sp_m2    = sp - WIDTH'(2);
  assign op_ready = (state_q == ST_IDLE);
  assign accept   = op_valid && op_ready;
  assign depth    = depth_q;
  assign empty    = (depth_q == '0);
  assign full     = (depth_q == (WIDTH+1)'(SIZE));

`ifdef STACK_GUARD_EN
  logic ov_q, un_q;

  always_comb begin
    bad_ov = accept && full &&
             (op == OP_PUSH || op == OP_DUP || op == OP_OVER);
    bad_un = accept &&
             ((op == OP_POP && empty) ||
              ((op == OP_BINOP || op == OP_SWAP || op == OP_OVER) &&
               depth_q < (WIDTH+1)'(2)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q <= 1'b0;
      un_q <= 1'b0;
    end else if (state_q == ST_ERROR && err_clr) begin
      ov_q <= 1'b0;
      un_q <= 1'b0;
    end else begin
      if (bad_ov) ov_q <= 1'b1;
      if (bad_un) un_q <= 1'b1;
    end
  end

  assign err_overflow  = ov_q;
  assign err_underflow = un_q;
`else
  assign bad_ov        = 1'b0;
  assign bad_un        = 1'b0;
  assign err_overflow  = 1'b0;
  assign err_underflow = 1'b0;
`endif

  // Next-state, depth and write-port mux.
  // NOTE: every signal gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    we      = 1'b0;
    waddr   = sp;
    wdata   = din;
    unique case (state_q)
      ST_IDLE: begin
        if (bad_ov || bad_un) begin
          state_d = ST_ERROR;
        end else if (accept) begin
          unique case (op)
            OP_PUSH: begin
              we      = 1'b1;
              depth_d = depth_q + (WIDTH+1)'(1);
            end
            OP_POP: depth_d = depth_q - (WIDTH+1)'(1);
            OP_BINOP: begin
              we      = 1'b1;
              waddr   = sp_m2;
              depth_d = depth_q - (WIDTH+1)'(1);
            end
            OP_DUP: begin
              we      = 1'b1;
              wdata   = tos;
              depth_d = depth_q + (WIDTH+1)'(1);
            end
            OP_OVER: begin
              we      = 1'b1;
              wdata   = nos;
              depth_d = depth_q + (WIDTH+1)'(1);
            end
            OP_SWAP: begin
              we      = 1'b1;
              waddr   = sp_m1;
              wdata   = nos;
              state_d = ST_SWAP2;
            end
            default: ;
          endcase
        end
      end
      ST_SWAP2: begin
        we      = 1'b1;
        waddr   = sp_m2;
        wdata   = swap_tmp;
        state_d = ST_IDLE;
      end
      ST_ERROR: if (err_clr) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      depth_q  <= '0;
      swap_tmp <= '0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      if (accept && op == OP_SWAP && !bad_un) begin
        swap_tmp <= tos;
      end
    end
  end

  // Write enable is forced low while reset is held so an opcode presented
  // during reset cannot corrupt the RAM.
  stack #(
    .WIDTH (WIDTH),
    .SIZE  (SIZE)
  ) u_stack (
    .clk     (clk),
    .we      (we && rst_n),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (sp_m1),
    .rdata_a (tos),
    .raddr_b (sp_m2),
    .rdata_b (nos)
  );

endmodule

// File: tb/tb_stack_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stack_ctrl
// Scoreboard bench for stack_ctrl. The driver issues directed and random
// opcodes, advances a word-array model of the stack and queues the expected
// outputs; a separate monitor pops one expectation per falling edge and
// compares. Works with and without STACK_GUARD_EN.
// -----------------------------------------------------------------------------
module tb_stack_ctrl;
  import stack_ctrl_pkg::*;

  localparam int WIDTH = 5;
  localparam int SIZE  = 32;
`ifdef STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              op_valid = 1'b0;
  logic              op_ready;
  stack_op_t         op = OP_NOP;
  logic [DATA_W-1:0] din = '0;
  logic [DATA_W-1:0] tos, nos;
  logic [WIDTH:0]    depth;
  logic              empty, full, err_overflow, err_underflow;
  logic              err_clr = 1'b0;

  always #5 clk = ~clk;

  stack_ctrl #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .op_valid      (op_valid),
    .op_ready      (op_ready),
    .op            (op),
    .din           (din),
    .tos           (tos),
    .nos           (nos),
    .depth         (depth),
    .empty         (empty),
    .full          (full),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow),
    .err_clr       (err_clr)
  );

  typedef struct {
    string       tag;
    bit          ready;
    int          depth;
    logic [15:0] tos;
    logic [15:0] nos;
    bit          tos_v;
    bit          nos_v;
    bit          ov;
    bit          un;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: a plain word array indexed modulo SIZE, a depth count,
  // which slots hold known data, and the pending half of an in-flight SWAP.
  logic [15:0] m [SIZE];
  bit          k [SIZE];
  int          d;
  bit          busy, err, mov, mun;
  int          pend_slot;
  logic [15:0] pend_val;
  bit          pend_k;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int slot(input int off);
    return (d + off) & (SIZE - 1);
  endfunction

  task automatic push_exp(input string tag);
    exp_t e;
    e.tag   = tag;
    e.ready = !busy && !err;
    e.depth = d;
    e.tos   = m[slot(-1)];
    e.nos   = m[slot(-2)];
    e.tos_v = !busy && d != 0 && k[slot(-1)];
    e.nos_v = !busy && d != 0 && k[slot(-2)];
    e.ov    = mov;
    e.un    = mun;
    sb.push_back(e);
  endtask

  task automatic model_reset();
    d = 0; busy = 0; err = 0; mov = 0; mun = 0;
  endtask

  task automatic model_step(input bit v, input stack_op_t o, input logic [15:0] dv, input bit clr);
    int s0, s1, s2;
    bit o_ov, o_un;
    s0 = slot(0); s1 = slot(-1); s2 = slot(-2);
    if (busy) begin
      m[pend_slot] = pend_val;
      k[pend_slot] = pend_k;
      busy = 0;
    end else if (err) begin
      if (clr) begin err = 0; mov = 0; mun = 0; end
    end else if (v) begin
      o_ov = GUARD && d == SIZE && (o == OP_PUSH || o == OP_DUP || o == OP_OVER);
      o_un = GUARD && ((o == OP_POP && d == 0) ||
                       ((o == OP_BINOP || o == OP_SWAP || o == OP_OVER) && d < 2));
      if (o_ov || o_un) begin
        err = 1; mov = mov | o_ov; mun = mun | o_un;
      end else begin
        case (o)
          OP_PUSH:  begin m[s0] = dv;    k[s0] = 1;     d = d + 1; end
          OP_POP:   d = d - 1;
          OP_BINOP: begin m[s2] = dv;    k[s2] = 1;     d = d - 1; end
          OP_DUP:   begin m[s0] = m[s1]; k[s0] = k[s1]; d = d + 1; end
          OP_OVER:  begin m[s0] = m[s2]; k[s0] = k[s2]; d = d + 1; end
          OP_SWAP: begin
            pend_slot = s2; pend_val = m[s1]; pend_k = k[s1];
            m[s1] = m[s2]; k[s1] = k[s2];
            busy = 1;
          end
          default: ;
        endcase
        d = d & (2 * SIZE - 1);
      end
    end
  endtask

  // One clock of stimulus: drive on the falling edge, update the model just
  // after the rising edge and queue what the DUT must show.
  task automatic cyc(input string tag, input bit v, input stack_op_t o,
                     input logic [15:0] dv = '0, input bit clr = 0);
    @(negedge clk);
    op_valid = v; op = o; din = dv; err_clr = clr;
    @(posedge clk);
    #1;
    model_step(v, o, dv, clr);
    push_exp(tag);
  endtask

  task automatic idle(input string tag);
    cyc(tag, 1'b0, OP_NOP);
  endtask

  // Reset is applied just after a falling edge so it lands mid-cycle; the
  // reset state is checked while rst_n is still low.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    op_valid = 0; err_clr = 0; rst_n = 0;
    model_reset();
    push_exp(tag);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1;
  endtask

  // Monitor: one expectation per falling edge, outputs are stable there.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.tag, " ready"}, op_ready, e.ready);
        check({e.tag, " depth"}, depth, e.depth);
        check({e.tag, " empty"}, empty, e.depth == 0);
        check({e.tag, " full"}, full, e.depth == SIZE);
        check({e.tag, " ovf"}, err_overflow, e.ov);
        check({e.tag, " udf"}, err_underflow, e.un);
        if (e.tos_v) check({e.tag, " tos"}, tos, e.tos);
        if (e.nos_v) check({e.tag, " nos"}, nos, e.nos);
      end
    end
  end

  initial begin
    stack_op_t ro;
    for (int i = 0; i < SIZE; i++) begin m[i] = '0; k[i] = 0; end
    model_reset();

    do_reset("reset");
    idle("post_reset");

    cyc("push1", 1, OP_PUSH, 16'h1111);
    cyc("push2", 1, OP_PUSH, 16'h2222);
    cyc("swap", 1, OP_SWAP);
    idle("swap_done");

    do_reset("reset2");
    cyc("push3", 1, OP_PUSH, 16'd3);
    cyc("push5", 1, OP_PUSH, 16'd5);
    cyc("binop", 1, OP_BINOP, 16'd8);
    cyc("dup", 1, OP_DUP);
    cyc("over", 1, OP_OVER);
    // An op held during SWAP2 must wait one cycle.
    cyc("swap_b", 1, OP_SWAP);
    cyc("held_push", 1, OP_PUSH, 16'hBEEF);
    cyc("held_push2", 1, OP_PUSH, 16'hBEEF);

    do_reset("reset3");
    cyc("pop_empty", 1, OP_POP);
    idle("err_hold");
    cyc("err_clr", 0, OP_NOP, '0, 1);
    idle("after_clr");

    do_reset("reset4");
    for (int i = 0; i < SIZE; i++) cyc("fill", 1, OP_PUSH, 16'h0100 + 16'(i));
    cyc("push33", 1, OP_PUSH, 16'hDEAD);
    idle("after33");
    cyc("clr33", 0, OP_NOP, '0, 1);
    idle("after_clr33");

    do_reset("reset5");
    cyc("sw_push1", 1, OP_PUSH, 16'h1111);
    cyc("sw_push2", 1, OP_PUSH, 16'h2222);
    cyc("sw_swap", 1, OP_SWAP);
    do_reset("reset_mid_swap");
    idle("after_abort");
    // Walk depth back to 34 (wrapping when unguarded) so slots 0/1 become
    // visible again and an unaborted second SWAP write would show on nos.
    for (int i = 0; i < 30; i++) cyc("unwind", 1, OP_POP);
    cyc("unwind_clr", 0, OP_NOP, '0, 1);
    idle("after_unwind");

    do_reset("reset_rand");
    for (int i = 0; i < 600; i++) begin
      ro = stack_op_t'($urandom_range(0, 6));
      if ($urandom_range(0, 2) == 0) ro = OP_PUSH;
      cyc("rand", $urandom_range(0, 3) != 0, ro, 16'($urandom),
          $urandom_range(0, 3) == 0);
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    check("drain", sb.size(), 0);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
